// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind a UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout flag; otherwise timeout is tied to 0.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int AW             = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 43400
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clear,
    output logic          timeout
);

    if ((1 << AW) != DEPTH || DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        ovf_q, ovf_d;
    logic        push, pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count    = wr_q - rd_q;
    assign m_valid  = ~empty;
    assign m_data   = mem_q[rd_q[AW-1:0]];
    assign overflow = ovf_q;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign pop  = m_valid & m_ready;
    assign push = rx_valid & (~full | pop);

    always_comb begin
        wr_d  = push ? wr_q + PTR_ONE : wr_q;
        rd_d  = pop  ? rd_q + PTR_ONE : rd_q;
        ovf_d = ovf_q;
        if (rx_valid && !push) ovf_d = 1'b1;
        else if (ovf_clear)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= rx_data;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int             IW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0]  TMAX = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;

    // Judged on next-state values so the flag drops right after a push or a drain.
    always_comb begin
        idle_d = idle_q;
        if (push || (wr_d == rd_d)) idle_d = '0;
        else if (idle_q != TMAX)    idle_d = idle_q + IW'(1);
        timeout_d = (idle_d == TMAX) && (wr_d != rd_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int TC    = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       full, empty, overflow, ovf_clear, timeout;

    int errors = 0;
    int checks = 0;

    byte unsigned mq[$];
    bit           movf;

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .ovf_clear(ovf_clear),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs currently applied.
    task automatic tick();
        bit p, w;
        p = (mq.size() > 0) && m_ready;
        w = rx_valid && ((mq.size() < DEPTH) || p);
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(rx_data);
        if (rx_valid && !w) movf = 1'b1;
        else if (ovf_clear) movf = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 0; m_ready = 0; ovf_clear = 0; rx_data = 8'h00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        mq.delete(); movf = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic push_byte(input byte unsigned b);
        rx_valid = 1; rx_data = b;
        tick();
        rx_valid = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({empty, full, m_valid, overflow, timeout} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got e/f/v/o/t=%b exp 10000", {empty, full, m_valid, overflow, timeout});
        end
    endtask

    task automatic test_basic();
        byte unsigned exp;
        push_byte(8'h41);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h41) begin
            errors++; $display("FAIL basic_first got v=%b d=%h exp v=1 d=41", m_valid, m_data);
        end
        push_byte(8'h42);
        push_byte(8'h43);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
        m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            exp = 8'(8'h41 + i);
            checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
                errors++; $display("FAIL basic_read%0d got v=%b d=%h exp %h", i, m_valid, m_data, exp);
            end
            tick();
        end
        m_ready = 0;
        checks++; if (empty !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL basic_empty got e=%b v=%b exp 1 0", empty, m_valid);
        end
    endtask

    task automatic test_full_overflow();
        byte unsigned last;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL full_state got f=%b c=%0d exp 1 16", full, count);
        end
        push_byte(8'hFF);
        checks++; if (overflow !== 1'b1 || count !== 5'd16 || m_data !== 8'h00) begin
            errors++; $display("FAIL ovf_drop got o=%b c=%0d d=%h exp 1 16 00", overflow, count, m_data);
        end
        ovf_clear = 1; tick(); ovf_clear = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        push_byte(8'hFE);
        ovf_clear = 1; rx_valid = 1; rx_data = 8'hFD; tick(); rx_valid = 0; ovf_clear = 0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_prio got %b exp 1", overflow); end
        ovf_clear = 1; tick(); ovf_clear = 0;
        // Full FIFO, simultaneous push and pop.
        rx_valid = 1; rx_data = 8'hAA; m_ready = 1;
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL fullpp_head got %h exp 00", m_data); end
        tick(); rx_valid = 0; m_ready = 0;
        checks++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++; $display("FAIL fullpp_state got c=%0d o=%b f=%b exp 16 0 1", count, overflow, full);
        end
        m_ready = 1;
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== mq[0]) begin
                errors++; $display("FAIL drain%0d got v=%b d=%h exp %h", i, m_valid, m_data, mq[0]);
            end
            last = m_data;
            tick();
        end
        m_ready = 0;
        checks++; if (last !== 8'hAA || empty !== 1'b1) begin
            errors++; $display("FAIL drain_last got d=%h e=%b exp AA 1", last, empty);
        end
    endtask

    task automatic test_wrap();
        int sent = 0, bad = 0;
        for (int cyc = 0; cyc < 400 && (sent < 40 || mq.size() > 0); cyc++) begin
            m_ready  = ($urandom_range(0, 99) < 60);
            rx_valid = (sent < 40) && ($urandom_range(0, 1) == 1) && ((mq.size() < DEPTH) || m_ready);
            rx_data  = 8'($urandom);
            if (m_valid !== (mq.size() > 0) || count !== 5'(mq.size()) || count > 5'd16 ||
                (mq.size() > 0 && m_data !== mq[0])) begin
                bad++;
                if (bad < 4) $display("FAIL wrap_cyc%0d got v=%b c=%0d d=%h exp c=%0d d=%h",
                                      cyc, m_valid, count, m_data, mq.size(), (mq.size() > 0) ? mq[0] : 8'h00);
            end
            if (rx_valid) sent++;
            tick();
        end
        idle_inputs();
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_stream got %0d bad cycles exp 0", bad); end
        checks++; if (sent != 40 || empty !== 1'b1 || overflow !== movf || overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_end got sent=%0d e=%b o=%b exp 40 1 0", sent, empty, overflow);
        end
    endtask

    task automatic test_timeout();
        int k;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        push_byte(8'h11);
        k = 0;
        while (timeout !== 1'b1 && k < 200) begin tick(); k++; end
        checks++; if (k < 98 || k > 102) begin errors++; $display("FAIL to_rise got %0d cycles exp ~%0d", k, TC); end
        push_byte(8'h22);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_push_clear got %b exp 0", timeout); end
        m_ready = 1; tick(); tick(); m_ready = 0;
        for (int i = 0; i < 150; i++) tick();
        checks++; if (timeout !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL to_empty got t=%b e=%b exp 0 1", timeout, empty);
        end
        push_byte(8'h33);
        k = 0;
        while (timeout !== 1'b1 && k < 200) begin tick(); k++; end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_rise2 got %b exp 1", timeout); end
        apply_reset();
        checks++; if (timeout !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL to_reset got t=%b c=%0d exp 0 0", timeout, count);
        end
`else
        push_byte(8'h11);
        k = 0;
        for (int i = 0; i < 150; i++) begin tick(); if (timeout !== 1'b0) k++; end
        checks++; if (k != 0 || count !== 5'd1) begin
            errors++; $display("FAIL to_tied got %0d high cycles c=%0d exp 0 1", k, count);
        end
        apply_reset();
        checks++; if (count !== 5'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid got c=%0d v=%b exp 0 0", count, m_valid);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
